// File: rtl/aes_pkg.sv
// Shared AES primitives, FSM encodings and parameter helpers for the iterative core.
package aes_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Column bytes a0..a3 map to bits [31:24]..[7:0] (row 0 first).
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic int aes_nr(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of on-the-fly AES key expansion: slides the key window and yields the round key.
module aes_key_step
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic [KEY_BITS-1:0] i_window,
    input  logic [7:0]          i_rcon,
    input  logic                i_odd,
    output logic [KEY_BITS-1:0] o_window,
    output logic [127:0]        o_rk
);

    generate
        if (KEY_BITS == 128) begin : g_k128
            logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;
            logic        w_unused_odd;

            assign w_unused_odd = i_odd;
            assign w_t  = sub_word(rot_word(i_window[31:0])) ^ {i_rcon, 24'h0};
            assign w_n0 = i_window[127:96] ^ w_t;
            assign w_n1 = i_window[95:64]  ^ w_n0;
            assign w_n2 = i_window[63:32]  ^ w_n1;
            assign w_n3 = i_window[31:0]   ^ w_n2;
            assign o_window = {w_n0, w_n1, w_n2, w_n3};
            assign o_rk     = {w_n0, w_n1, w_n2, w_n3};
        end else begin : g_k256
            logic [127:0] w_hi, w_lo;
            logic [31:0]  w_pre, w_t, w_n0, w_n1, w_n2, w_n3;

            assign w_hi = i_window[255:128];
            assign w_lo = i_window[127:0];
            // Odd steps take RotWord+Rcon; even steps only SubWord. One S-box row serves both.
            assign w_pre = i_odd ? rot_word(w_lo[31:0]) : w_lo[31:0];
            assign w_t   = sub_word(w_pre) ^ (i_odd ? {i_rcon, 24'h0} : 32'h0);
            assign w_n0  = w_hi[127:96] ^ w_t;
            assign w_n1  = w_hi[95:64]  ^ w_n0;
            assign w_n2  = w_hi[63:32]  ^ w_n1;
            assign w_n3  = w_hi[31:0]   ^ w_n2;
            assign o_window = {w_lo, w_n0, w_n1, w_n2, w_n3};
            assign o_rk     = w_lo;
        end
    endgenerate

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one full round per clock, valid/ready on both sides.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                pi_clk,
    input  logic                pi_rst_n,
    input  logic                pi_in_valid,
    output logic                po_in_ready,
    input  logic [KEY_BITS-1:0] pi_key,
    input  logic [127:0]        pi_data,
    output logic                po_out_valid,
    input  logic                pi_out_ready,
    output logic [127:0]        po_out
);

    localparam int         NR         = aes_nr(KEY_BITS);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_iter_core: KEY_BITS must be 128 or 256");
        end
    endgenerate

    logic [1:0]          r_fsm;
    logic [127:0]        r_state;
    logic [3:0]          r_round;
    logic [7:0]          r_rcon;
    logic [KEY_BITS-1:0] r_key;
    logic [127:0]        r_out;

    logic [127:0]        w_sub, w_shift, w_mix, w_rk, w_round_res;
    logic [KEY_BITS-1:0] w_key_next;
    logic [7:0]          w_rcon_next;

    // Byte n sits at bits [127-8n -: 8]: row n%4, column n/4.
    generate
        for (genvar i = 0; i < 16; i++) begin : g_sub
            assign w_sub[127-8*i -: 8] = sbox(r_state[127-8*i -: 8]);
        end
        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                assign w_shift[127-8*(4*c+r) -: 8] = w_sub[127-8*(4*((c+r)%4)+r) -: 8];
            end
            assign w_mix[127-32*c -: 32] = mix_column(w_shift[127-32*c -: 32]);
        end
    endgenerate

    aes_key_step #(
        .KEY_BITS(KEY_BITS)
    ) u_key_step (
        .i_window(r_key),
        .i_rcon  (r_rcon),
        .i_odd   (r_round[0]),
        .o_window(w_key_next),
        .o_rk    (w_rk)
    );

    assign w_round_res = ((r_round == LAST_ROUND) ? w_shift : w_mix) ^ w_rk;
    assign w_rcon_next = (KEY_BITS == 128 || r_round[0]) ? xtime(r_rcon) : r_rcon;

    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_round <= '0;
            r_rcon  <= '0;
            r_key   <= '0;
            r_out   <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (pi_in_valid) begin
                        r_state <= pi_data ^ pi_key[KEY_BITS-1 -: 128];
                        r_key   <= pi_key;
                        r_round <= 4'd1;
                        r_rcon  <= RCON_INIT;
                        r_fsm   <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_state <= w_round_res;
                    r_key   <= w_key_next;
                    r_rcon  <= w_rcon_next;
                    if (r_round == LAST_ROUND) begin
                        r_out <= w_round_res;
                        r_fsm <= ST_DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (pi_out_ready) r_fsm <= ST_IDLE;
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign po_in_ready  = (r_fsm == ST_IDLE);
    assign po_out_valid = (r_fsm == ST_DONE);
    assign po_out       = r_out;

endmodule
